md_unit: RTL and testbench

Multiply/divide unit in the execute stage, directly downstream of the D/E pipeline register. Consumes the execute-stage MD control (`startE`, `MDopE`, `MDsignE`, `immWriteE`, `HIWriteE`, `HIReadE`) plus forwarded operands. Runs multi-cycle mult/div, owns the HI/LO architectural registers and raises a busy/stall request toward the hazard unit.

---
 rtl/md_unit_if.sv | 28 ++
 rtl/md_unit.sv | 129 ++++++++++++
 tb/tb_md_unit.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/md_unit_if.sv
// Execute-stage multiply/divide control and operand bundle.
//   master: drives MD control, read select, operands and respon; observes busyE/HLOutE
//   slave : the md_unit side
interface md_unit_if;
  logic        startE;
  logic [1:0]  MDopE;
  logic        MDsignE;
  logic        immWriteE;
  logic        HIWriteE;
  logic        HIReadE;
  logic [31:0] srcAE;
  logic [31:0] srcBE;
  logic        respon;
  logic        busyE;
  logic [31:0] HLOutE;

  modport master (
    output startE, MDopE, MDsignE, immWriteE, HIWriteE, HIReadE,
    output srcAE, srcBE, respon,
    input  busyE, HLOutE
  );

  modport slave (
    input  startE, MDopE, MDsignE, immWriteE, HIWriteE, HIReadE,
    input  srcAE, srcBE, respon,
    output busyE, HLOutE
  );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// The result is computed at launch and held pending; it is committed to
// HI/LO after MULT_CYCLES or DIV_CYCLES busy cycles.
//   clk    : rising-edge clock
//   resetn : asynchronous active-low reset
//   md     : slave side of md_unit_if (MD control, operands, busyE, HLOutE)
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic     clk,
  input  logic     resetn,
  md_unit_if.slave md
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   hi_q;
  logic [DATA_W-1:0]   lo_q;
  logic [DATA_W-1:0]   res_hi_q;
  logic [DATA_W-1:0]   res_lo_q;
  logic                div_zero_q;

  logic                busy_c;
  logic                go_c;
  logic                wr_c;
  logic                is_div_c;
  logic                div_zero_c;
  logic [DATA_W-1:0]   divisor_c;
  logic                ext_a_c;
  logic                ext_b_c;
  logic [2*DATA_W-1:0] prod_c;
  logic signed [DATA_W-1:0] quo_s_c;
  logic signed [DATA_W-1:0] rem_s_c;
  logic [DATA_W-1:0]   quo_u_c;
  logic [DATA_W-1:0]   rem_u_c;
  logic [DATA_W-1:0]   new_hi_c;
  logic [DATA_W-1:0]   new_lo_c;

  assign busy_c   = (state_q == RUN);
  assign is_div_c = md.MDopE[0];

  // Reserved opcodes (1x) never launch; kills and busy also suppress launch/write.
  assign go_c = md.startE & ~md.respon & ~busy_c & ~md.MDopE[1];
  assign wr_c = md.immWriteE & ~md.respon & ~busy_c;

  // Sign- or zero-extend to 64 bits; the low 64 bits of the product are then
  // correct for both signed and unsigned operands.
  assign ext_a_c = md.MDsignE & md.srcAE[DATA_W-1];
  assign ext_b_c = md.MDsignE & md.srcBE[DATA_W-1];
  assign prod_c  = {{DATA_W{ext_a_c}}, md.srcAE} * {{DATA_W{ext_b_c}}, md.srcBE};

  // Substitute a divisor of 1 on divide-by-zero so the divider stays defined;
  // the result is discarded anyway.
  assign div_zero_c = (md.srcBE == '0);
  assign divisor_c  = div_zero_c ? DATA_W'(1) : md.srcBE;

  assign quo_s_c = $signed(md.srcAE) / $signed(divisor_c);
  assign rem_s_c = $signed(md.srcAE) % $signed(divisor_c);
  assign quo_u_c = md.srcAE / divisor_c;
  assign rem_u_c = md.srcAE % divisor_c;

  // Pending result selection at launch.
  always_comb begin
    new_hi_c = prod_c[2*DATA_W-1:DATA_W];
    new_lo_c = prod_c[DATA_W-1:0];
    if (is_div_c) begin
      if (md.MDsignE) begin
        new_hi_c = DATA_W'(rem_s_c);
        new_lo_c = DATA_W'(quo_s_c);
      end else begin
        new_hi_c = rem_u_c;
        new_lo_c = quo_u_c;
      end
    end
  end

  // Sequencer, architectural HI/LO and pending result.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      res_hi_q   <= '0;
      res_lo_q   <= '0;
      div_zero_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (go_c) begin
            state_q    <= RUN;
            cnt_q      <= is_div_c ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            res_hi_q   <= new_hi_c;
            res_lo_q   <= new_lo_c;
            div_zero_q <= is_div_c & div_zero_c;
          end else if (wr_c) begin
            if (md.HIWriteE) hi_q <= md.srcAE;
            else             lo_q <= md.srcAE;
          end
        end
        RUN: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= IDLE;
            if (!div_zero_q) begin
              hi_q <= res_hi_q;
              lo_q <= res_lo_q;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stall request covers the launch cycle itself; reads see architectural state only.
  assign md.busyE  = busy_c | go_c;
  assign md.HLOutE = md.HIReadE ? hi_q : lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: stimulus pushes expected values tagged with a
// cycle number; a monitor compares them on the falling edge of that cycle.
module tb_md_unit;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  md_unit_if bus ();

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .resetn (resetn),
    .md     (bus)
  );

  typedef struct {
    int          cyc;
    bit          is_hl;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input bit is_hl, input logic [31:0] v, input string nm);
    exp_t e;
    e.cyc   = cyc;
    e.is_hl = is_hl;
    e.val   = v;
    e.name  = nm;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.startE    = 1'b0;
    bus.MDopE     = 2'b00;
    bus.MDsignE   = 1'b0;
    bus.immWriteE = 1'b0;
    bus.HIWriteE  = 1'b0;
    bus.HIReadE   = 1'b0;
    bus.srcAE     = '0;
    bus.srcBE     = '0;
    bus.respon    = 1'b0;
  endtask

  // Monitor: compares every expectation due in the current cycle.
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        e   = sb_q.pop_front();
        act = e.is_hl ? bus.HLOutE : {31'd0, bus.busyE};
        n_chk++;
        if (act === e.val) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", e.name, act, e.val, cyc);
      end
    end
  end

  // Launch one op, optionally inject respon or colliding requests, then read HI and LO.
  task automatic run_op(input logic [1:0] op, input bit sgn, input logic [31:0] a,
                        input logic [31:0] b, input int n, input logic [31:0] hi,
                        input logic [31:0] lo, input string nm, input int respon_at,
                        input bit coll);
    tick(); idle_in();
    bus.startE = 1'b1; bus.MDopE = op; bus.MDsignE = sgn; bus.srcAE = a; bus.srcBE = b;
    push(1'b0, 32'd1, {nm, " busy@launch"});
    for (int k = 1; k <= n; k++) begin
      tick(); idle_in();
      if (k == respon_at) bus.respon = 1'b1;
      if (coll && k == 2) begin
        bus.immWriteE = 1'b1; bus.HIWriteE = 1'b1; bus.srcAE = 32'hDEADBEEF;
      end
      if (coll && k == 3) begin
        bus.startE = 1'b1; bus.MDopE = 2'b01; bus.srcAE = 32'd1; bus.srcBE = 32'd1;
      end
      push(1'b0, 32'd1, {nm, " busy"});
    end
    tick(); idle_in();
    bus.HIReadE = 1'b1;
    push(1'b0, 32'd0, {nm, " busy_done"});
    push(1'b1, hi, {nm, " HI"});
    tick(); idle_in();
    bus.HIReadE = 1'b0;
    push(1'b1, lo, {nm, " LO"});
  endtask

  initial begin
    idle_in();
    resetn = 1'b0;

    // Reset state
    tick(); idle_in(); bus.HIReadE = 1'b1;
    push(1'b1, 32'd0, "rst HI");
    push(1'b0, 32'd0, "rst busy");
    tick(); idle_in();
    push(1'b1, 32'd0, "rst LO");
    tick(); idle_in(); resetn = 1'b1;
    push(1'b0, 32'd0, "post_rst busy");
    push(1'b1, 32'd0, "post_rst LO");

    run_op(2'b00, 1'b1, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA, "mult_s", -1, 1'b0);
    run_op(2'b00, 1'b0, 32'hFFFFFFFE, 32'd3, 5, 32'h00000002, 32'hFFFFFFFA, "multu", -1, 1'b0);
    run_op(2'b01, 1'b1, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_s", -1, 1'b0);
    run_op(2'b01, 1'b0, 32'd7, 32'd2, 10, 32'd1, 32'd3, "divu", -1, 1'b0);

    // mthi 0x11, mtlo 0x22
    tick(); idle_in();
    bus.immWriteE = 1'b1; bus.HIWriteE = 1'b1; bus.srcAE = 32'h11;
    push(1'b0, 32'd0, "mthi busy");
    tick(); idle_in();
    bus.immWriteE = 1'b1; bus.HIWriteE = 1'b0; bus.srcAE = 32'h22; bus.HIReadE = 1'b1;
    push(1'b1, 32'h11, "mthi HI");
    push(1'b0, 32'd0, "mtlo busy");
    tick(); idle_in();
    push(1'b1, 32'h22, "mtlo LO");

    run_op(2'b01, 1'b1, 32'd5, 32'd0, 10, 32'h11, 32'h22, "div0", -1, 1'b0);

    // Start and mthi killed by respon; reserved opcode is a no-op
    tick(); idle_in();
    bus.startE = 1'b1; bus.srcAE = 32'd3; bus.srcBE = 32'd3; bus.respon = 1'b1; bus.HIReadE = 1'b1;
    push(1'b0, 32'd0, "kill busy");
    tick(); idle_in(); bus.HIReadE = 1'b1;
    push(1'b0, 32'd0, "kill busy_next");
    push(1'b1, 32'h11, "kill HI");
    bus.immWriteE = 1'b1; bus.HIWriteE = 1'b1; bus.srcAE = 32'h99; bus.respon = 1'b1;
    tick(); idle_in(); bus.HIReadE = 1'b1;
    push(1'b1, 32'h11, "kill_mthi HI");
    bus.startE = 1'b1; bus.MDopE = 2'b10; bus.srcAE = 32'd4; bus.srcBE = 32'd4;
    push(1'b0, 32'd0, "rsvd busy");
    tick(); idle_in();
    push(1'b0, 32'd0, "rsvd busy_next");
    push(1'b1, 32'h22, "rsvd LO");

    run_op(2'b00, 1'b0, 32'd100, 32'd200, 5, 32'd0, 32'h4E20, "mult_respon", 2, 1'b0);
    run_op(2'b00, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFB, 5, 32'd0, 32'hF, "mult_coll", -1, 1'b1);

    // mtlo 0xABCD in IDLE
    tick(); idle_in();
    bus.immWriteE = 1'b1; bus.HIWriteE = 1'b0; bus.srcAE = 32'hABCD;
    push(1'b0, 32'd0, "mtlo2 busy");
    tick(); idle_in();
    push(1'b1, 32'hABCD, "mtlo2 LO");
    tick(); idle_in(); bus.HIReadE = 1'b1;
    push(1'b1, 32'd0, "mtlo2 HI");

    // Reset asserted mid-divide (cnt = 4): op aborted, never commits
    tick(); idle_in();
    bus.startE = 1'b1; bus.MDopE = 2'b01; bus.srcAE = 32'd100; bus.srcBE = 32'd7;
    push(1'b0, 32'd1, "abort busy@launch");
    for (int k = 1; k <= 6; k++) begin
      tick(); idle_in();
      push(1'b0, 32'd1, "abort busy");
    end
    tick(); idle_in(); resetn = 1'b0;
    push(1'b0, 32'd0, "abort busy_rst");
    push(1'b1, 32'd0, "abort LO_rst");
    tick(); idle_in(); resetn = 1'b1; bus.HIReadE = 1'b1;
    push(1'b1, 32'd0, "abort HI_rst");
    for (int k = 0; k < 6; k++) begin
      tick(); idle_in(); bus.HIReadE = k[0];
      push(1'b0, 32'd0, "abort busy_after");
      push(1'b1, 32'd0, "abort HL_after");
    end

    tick(); tick();
    if (sb_q.size() != 0) begin
      n_chk++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
